// File: rtl/gpu_wb_pkg.sv
// Shared types and constants for the scalar writeback path.
package gpu_wb_pkg;
    localparam int unsigned NUM_WB_SRC = 3;
    localparam int unsigned REG_AW     = 5;
    localparam int unsigned WB_XLEN    = 32;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MDU = 2'd1,
        WB_LSU = 2'd2
    } wb_src_e;

    typedef struct packed {
        logic [REG_AW-1:0]  rd;
        logic [WB_XLEN-1:0] data;
    } wb_req_t;
endpackage

// File: rtl/wb_src_fifo.sv
// Per-source synchronous FIFO of writeback requests; push is ignored while full.
module wb_src_fifo
    import gpu_wb_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push,
    input  wb_req_t din,
    input  logic    pop,
    output logic    full,
    output logic    empty,
    output wb_req_t head
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    wb_req_t       mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    // Full/empty come from registered count, so a pop never frees a slot in the same cycle.
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (do_pop && !do_push) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/scalar_wb_arbiter.sv
// Round-robin writeback arbiter feeding the scalar regfile write port, with pending-write scoreboard.
// Optional WB_ARB_BYPASS_EN adds combinational byp_* outputs carrying the current arbitration winner.
module scalar_wb_arbiter
    import gpu_wb_pkg::*;
#(
    parameter int unsigned NUM_SRC    = NUM_WB_SRC,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned XLEN       = WB_XLEN,
    parameter int unsigned NREG       = 32
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_SRC-1:0]               src_valid,
    output logic [NUM_SRC-1:0]               src_ready,
    input  logic [NUM_SRC-1:0][REG_AW-1:0]   src_rd,
    input  logic [NUM_SRC-1:0][XLEN-1:0]     src_data,
    input  logic                             iss_valid,
    input  logic [REG_AW-1:0]                iss_rd,
    output logic [NREG-1:0]                  busy_mask,
    output logic                             rf_we,
    output logic [REG_AW-1:0]                rf_waddr,
    output logic [XLEN-1:0]                  rf_wdata
`ifdef WB_ARB_BYPASS_EN
    ,
    output logic                             byp_valid,
    output logic [REG_AW-1:0]                byp_rd,
    output logic [XLEN-1:0]                  byp_data
`endif
);
    localparam int unsigned PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0] full;
    logic [NUM_SRC-1:0] empty;
    logic [NUM_SRC-1:0] pop;
    wb_req_t            head [NUM_SRC];

    logic [PW-1:0]      rr_ptr;
    logic [PW-1:0]      win_idx;
    logic               win_valid;
    wb_req_t            win_req;
    logic [NREG-1:0]    busy_next;
    int                 idx;

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_fifo
        wb_req_t din;
        assign din.rd   = src_rd[gi];
        assign din.data = src_data[gi];

        wb_src_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (src_valid[gi]),
            .din   (din),
            .pop   (pop[gi]),
            .full  (full[gi]),
            .empty (empty[gi]),
            .head  (head[gi])
        );
    end

    assign src_ready = ~full;

    // Grant the first non-empty FIFO at or after rr_ptr.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int k = 0; k < int'(NUM_SRC); k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= int'(NUM_SRC)) idx = idx - int'(NUM_SRC);
            if (!win_valid && !empty[PW'(idx)]) begin
                win_valid = 1'b1;
                win_idx   = PW'(idx);
            end
        end
    end

    assign win_req = head[win_idx];

    always_comb begin
        pop          = '0;
        pop[win_idx] = win_valid;
    end

    // Retiring write clears its bit; a same-cycle reservation of the same register wins.
    always_comb begin
        busy_next = busy_mask;
        if (rf_we) busy_next[rf_waddr] = 1'b0;
        if (iss_valid && (iss_rd != '0)) busy_next[iss_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            rf_we     <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
            busy_mask <= '0;
        end else begin
            rf_we     <= win_valid && (win_req.rd != '0);
            busy_mask <= busy_next;
            if (win_valid) begin
                rf_waddr <= win_req.rd;
                rf_wdata <= win_req.data;
                rr_ptr   <= (win_idx == PW'(NUM_SRC - 1)) ? '0 : win_idx + PW'(1);
            end
        end
    end

`ifdef WB_ARB_BYPASS_EN
    assign byp_valid = win_valid && (win_req.rd != '0);
    assign byp_rd    = win_req.rd;
    assign byp_data  = win_req.data;
`endif
endmodule
